picosoc_iomem_bus: RTL and testbench
====================================

PICOSOC_IOMEM_BUS -- requirements
Module: picosoc_iomem_bus

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 6, number of iomem slave channels (legal 1..16).
REQ-002 SHALL have parameter SLAVE_REGION, default {8'h00,8'h02,8'h03,8'h04,8'h05,8'h06}, 8-bit addr[31:24] region per slave, index i = slave i.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, max ACTIVE cycles before forced response (legal 2..65535).
REQ-004 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, read data returned on unmapped or timed-out access.
REQ-005 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports m_valid in 1, m_instr in 1, m_wstrb in 4, m_addr in 32, m_wdata in 32: picorv32 master request.
REQ-008 SHALL have ports m_ready out 1, m_rdata out 32: master response.
REQ-009 SHALL have ports s_valid out NUM_SLAVES, s_wstrb out 4, s_addr out 32, s_wdata out 32, s_instr out 1: slave request; s_wstrb/s_addr/s_wdata/s_instr broadcast from master.
REQ-010 SHALL have ports s_ready in NUM_SLAVES, s_rdata in NUM_SLAVES x 32: slave responses.
REQ-011 SHALL have ports err_o out 1 (sticky), err_type_o out 1 (0 unmapped, 1 timeout), err_addr_o out 32, err_clr_i in 1.

Function
REQ-012 SHALL implement states IDLE, ACTIVE, RESPOND.
REQ-013 IDLE with m_valid=1: SHALL decode m_addr[31:24] against SLAVE_REGION, register one-hot sel; match -> ACTIVE; no match -> RESPOND with error.
REQ-014 Overlapping regions: lowest slave index SHALL win.
REQ-015 ACTIVE: s_valid[sel]=1, all other s_valid bits 0; s_valid SHALL be 0 in IDLE and RESPOND.
REQ-016 ACTIVE with s_ready[sel]=1: SHALL register s_rdata[sel] (one-hot AND-OR mux, selected by sel only, never by ready of unselected slaves), go RESPOND.
REQ-017 s_ready of unselected slaves SHALL be ignored.
REQ-018 RESPOND: m_ready=1 for exactly one cycle with registered m_rdata, then IDLE; m_ready SHALL be 0 in other states.
REQ-019 Latency: slave ready in cycle N -> m_ready in cycle N+1; unmapped request accepted in cycle N -> m_ready in N+1.
REQ-020 A new m_valid in the cycle after RESPOND SHALL be accepted as a new transaction (back-to-back, no idle gap beyond IDLE cycle).
REQ-021 Timeout counter SHALL clear on ACTIVE entry, increment each ACTIVE cycle; at TIMEOUT_CYCLES-1 without s_ready -> RESPOND, m_rdata=ERR_RDATA, error type timeout.
REQ-022 s_ready on same cycle as timeout expiry: slave response SHALL win, no error.
REQ-023 Unmapped: m_rdata=ERR_RDATA; writes discarded; error type unmapped.
REQ-024 Error capture: err_o<=1, err_type_o, err_addr_o<=m_addr; subsequent errors overwrite type/addr.
REQ-025 err_clr_i=1 SHALL clear err_o next cycle; simultaneous new error and clear: error SHALL win.
REQ-026 m_valid falling in ACTIVE (illegal abort): SHALL return to IDLE next cycle, s_valid drop, no m_ready, no error.
REQ-027 m_rdata SHALL hold its last value outside RESPOND.

Reset
REQ-028 reset SHALL force IDLE, sel=0, counter=0, m_ready=0, m_rdata=0, s_valid=0, err_o=0, err_type_o=0, err_addr_o=0, asynchronously.
REQ-029 reset mid-ACTIVE SHALL drop s_valid immediately; no response issued after release.

Structure
REQ-030 Package picosoc_pkg SHALL hold the bus state enum, error-type enum, and MAX_SLAVES=16 constant.
REQ-031 Counter width SHALL be $clog2(TIMEOUT_CYCLES).
REQ-032 One combinational sub-module picosoc_iomem_decode (addr region -> one-hot + hit) SHALL be used.

Verification
REQ-033 Read 0x0400_0010, slave 3 ready after 5 ACTIVE cycles with rdata 0x1234_5678 -> m_ready one cycle later, m_rdata=0x1234_5678, s_valid[3] only.
REQ-034 Read 0x0100_0000 (unmapped) -> m_ready next cycle, m_rdata=0xDEAD_BEEF, err_o=1, err_type_o=0, err_addr_o=0x0100_0000.
REQ-035 TIMEOUT_CYCLES=8, slave 1 never ready -> m_ready after 8 ACTIVE cycles, m_rdata=ERR_RDATA, err_type_o=1; s_ready in cycle 8 instead -> slave data, err_o=0.
REQ-036 Unselected slave 0 asserts s_ready=1 with 0xFFFF_FFFF during slave 2 transfer -> ignored; m_rdata from slave 2 only.
REQ-037 err_clr_i asserted with concurrent unmapped access -> err_o remains 1 with new address.
REQ-038 reset asserted in ACTIVE -> s_valid=0 same cycle, all outputs at reset values, no m_ready after release.

Source files
------------

// File: rtl/picosoc_pkg.sv
// picosoc_pkg: shared types and constants for the picosoc iomem bus.
//   bus_state_e - iomem bus FSM states
//   err_type_e  - error classification reported on err_type_o
//   MAX_SLAVES  - upper bound on the number of iomem slave channels
package picosoc_pkg;

    localparam int unsigned MAX_SLAVES = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StActive  = 2'd1,
        StRespond = 2'd2
    } bus_state_e;

    typedef enum logic {
        ErrUnmapped = 1'b0,
        ErrTimeout  = 1'b1
    } err_type_e;

endpackage

// File: rtl/picosoc_iomem_decode.sv
// picosoc_iomem_decode: combinational address-region decoder.
// Ports:
//   region - addr[31:24] of the master request
//   sel    - one-hot slave select (all zero when nothing matches)
//   hit    - at least one slave region matches
// SLAVE_REGION is written as a concatenation with slave 0 leftmost, so slave i
// lives at bits [(NUM_SLAVES-1-i)*8 +: 8].
module picosoc_iomem_decode #(
    parameter int unsigned                 NUM_SLAVES   = 6,
    parameter logic [8*NUM_SLAVES-1:0]     SLAVE_REGION = {8'h00, 8'h02, 8'h03,
                                                           8'h04, 8'h05, 8'h06}
) (
    input  logic [7:0]            region,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  hit
);

    always_comb begin
        sel = '0;
        hit = 1'b0;
        // Walk from the highest index down so the lowest matching index is the
        // last writer and therefore wins on overlapping regions.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (region == SLAVE_REGION[(NUM_SLAVES-1-i)*8 +: 8]) begin
                sel    = '0;
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/picosoc_iomem_bus.sv
// picosoc_iomem_bus: routes a picorv32 iomem request to one of NUM_SLAVES
// slaves by addr[31:24], with a per-access timeout and sticky error capture.
// Ports:
//   clk, reset                      - clock, asynchronous active-high reset
//   m_valid/m_instr/m_wstrb/m_addr/m_wdata - master request
//   m_ready/m_rdata                 - master response (one-cycle ready pulse)
//   s_valid[NUM_SLAVES]             - per-slave request strobe
//   s_wstrb/s_addr/s_wdata/s_instr  - request fields broadcast to all slaves
//   s_ready[NUM_SLAVES], s_rdata    - slave responses, slave i at [32*i +: 32]
//   err_o/err_type_o/err_addr_o     - sticky error flag, type and address
//   err_clr_i                       - clears err_o (a new error wins)
module picosoc_iomem_bus
    import picosoc_pkg::*;
#(
    parameter int unsigned             NUM_SLAVES     = 6,
    parameter logic [8*NUM_SLAVES-1:0] SLAVE_REGION   = {8'h00, 8'h02, 8'h03,
                                                          8'h04, 8'h05, 8'h06},
    parameter int unsigned             TIMEOUT_CYCLES = 1024,
    parameter logic [31:0]             ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     m_valid,
    input  logic                     m_instr,
    input  logic [3:0]               m_wstrb,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    output logic                     m_ready,
    output logic [31:0]              m_rdata,

    output logic [NUM_SLAVES-1:0]    s_valid,
    output logic [3:0]               s_wstrb,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic                     s_instr,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,

    output logic                     err_o,
    output logic                     err_type_o,
    output logic [31:0]              err_addr_o,
    input  logic                     err_clr_i
);

    localparam int unsigned      CntW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0]  CntLast = CntW'(TIMEOUT_CYCLES - 1);

    if (NUM_SLAVES < 1 || NUM_SLAVES > MAX_SLAVES) begin : g_bad_num_slaves
        $error("NUM_SLAVES out of range");
    end

    bus_state_e              state_q, state_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;
    err_type_e               err_type_q, err_type_d;
    logic [31:0]             err_addr_q, err_addr_d;

    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    dec_hit;
    logic                    sel_ready;
    logic [31:0]             sel_rdata;
    logic                    new_err;
    err_type_e               new_err_type;

    picosoc_iomem_decode #(
        .NUM_SLAVES   (NUM_SLAVES),
        .SLAVE_REGION (SLAVE_REGION)
    ) u_decode (
        .region (m_addr[31:24]),
        .sel    (dec_sel),
        .hit    (dec_hit)
    );

    // Ready and data are qualified by the registered select only, so an
    // unselected slave can never complete or corrupt the transfer.
    always_comb begin
        sel_ready = |(s_ready & sel_q);
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_rdata = sel_rdata | (s_rdata[32*i +: 32] & {32{sel_q[i]}});
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        new_err      = 1'b0;
        new_err_type = ErrUnmapped;

        unique case (state_q)
            StIdle: begin
                if (m_valid) begin
                    if (dec_hit) begin
                        sel_d   = dec_sel;
                        cnt_d   = '0;
                        state_d = StActive;
                    end else begin
                        // Unmapped: writes are dropped, reads get ERR_RDATA.
                        sel_d        = '0;
                        rdata_d      = ERR_RDATA;
                        new_err      = 1'b1;
                        new_err_type = ErrUnmapped;
                        state_d      = StRespond;
                    end
                end
            end
            StActive: begin
                if (!m_valid) begin
                    // Master withdrew the request: abandon silently.
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (sel_ready) begin
                    // Checked before the timeout so a last-cycle ready wins.
                    rdata_d = sel_rdata;
                    state_d = StRespond;
                end else if (cnt_q == CntLast) begin
                    rdata_d      = ERR_RDATA;
                    new_err      = 1'b1;
                    new_err_type = ErrTimeout;
                    state_d      = StRespond;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRespond: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        err_d      = err_q;
        err_type_d = err_type_q;
        err_addr_d = err_addr_q;
        if (new_err) begin
            err_d      = 1'b1;
            err_type_d = new_err_type;
            err_addr_d = m_addr;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_type_q <= ErrUnmapped;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            err_type_q <= err_type_d;
            err_addr_q <= err_addr_d;
        end
    end

    // s_valid and m_ready decode straight from the state register so an
    // asynchronous reset drops them in the same cycle.
    assign s_valid    = (state_q == StActive) ? sel_q : '0;
    assign m_ready    = (state_q == StRespond);
    assign m_rdata    = rdata_q;
    assign s_wstrb    = m_wstrb;
    assign s_addr     = m_addr;
    assign s_wdata    = m_wdata;
    assign s_instr    = m_instr;
    assign err_o      = err_q;
    assign err_type_o = err_type_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_picosoc_iomem_bus.sv
// Self-checking bench for picosoc_iomem_bus: transaction-level reference model
// with per-cycle comparison, directed scenarios and randomized traffic.
module tb_picosoc_iomem_bus;

    localparam int NS = 6;
    localparam int T  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    // Slave 5 duplicates slave 1's region so lowest-index priority is exercised.
    localparam logic [8*NS-1:0] REGIONS = {8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h02};
    logic [7:0] region_tbl [NS] = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h02};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              m_valid = 1'b0, m_instr = 1'b0;
    logic [3:0]        m_wstrb = '0;
    logic [31:0]       m_addr = '0, m_wdata = '0;
    logic              m_ready;
    logic [31:0]       m_rdata;
    logic [NS-1:0]     s_valid;
    logic [3:0]        s_wstrb;
    logic [31:0]       s_addr, s_wdata;
    logic              s_instr;
    logic [NS-1:0]     s_ready = '0;
    logic [32*NS-1:0]  s_rdata = '0;
    logic              err_o, err_type_o;
    logic [31:0]       err_addr_o;
    logic              err_clr_i = 1'b0;

    picosoc_iomem_bus #(
        .NUM_SLAVES     (NS),
        .SLAVE_REGION   (REGIONS),
        .TIMEOUT_CYCLES (T),
        .ERR_RDATA      (ERR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m_valid    (m_valid),
        .m_instr    (m_instr),
        .m_wstrb    (m_wstrb),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_ready    (m_ready),
        .m_rdata    (m_rdata),
        .s_valid    (s_valid),
        .s_wstrb    (s_wstrb),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_instr    (s_instr),
        .s_ready    (s_ready),
        .s_rdata    (s_rdata),
        .err_o      (err_o),
        .err_type_o (err_type_o),
        .err_addr_o (err_addr_o),
        .err_clr_i  (err_clr_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [NS-1:0] exp_s_valid = '0;
    logic          exp_m_ready = 1'b0;
    logic [31:0]   mdl_rdata = '0;
    logic          mdl_err = 1'b0;
    logic          mdl_type = 1'b0;
    logic [31:0]   mdl_addr = '0;
    bit            chk_en = 1'b0;
    bit            rand_clr_en = 1'b0;
    int            ready_cyc = -1;
    logic [NS-1:0] sv_or = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int model_decode(input logic [7:0] r);
        for (int i = 0; i < NS; i++) if (region_tbl[i] == r) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_valid", 32'(s_valid), 32'(exp_s_valid));
            chk("m_ready", 32'(m_ready), 32'(exp_m_ready));
            chk("m_rdata", m_rdata, mdl_rdata);
            chk("err_o", 32'(err_o), 32'(mdl_err));
            chk("err_type_o", 32'(err_type_o), 32'(mdl_type));
            chk("err_addr_o", err_addr_o, mdl_addr);
            chk("s_addr", s_addr, m_addr);
            chk("s_wdata", s_wdata, m_wdata);
            chk("s_wstrb", 32'(s_wstrb), 32'(m_wstrb));
            chk("s_instr", 32'(s_instr), 32'(m_instr));
            if (m_ready) ready_cyc = cyc;
            sv_or = sv_or | s_valid;
        end
    end

    // Advance one clock and apply the events of the cycle just ended to the model.
    task automatic tick(input bit ev, input bit ty, input logic [31:0] ad,
                        input bit rv, input logic [31:0] rd);
        @(posedge clk);
        if (ev) begin
            mdl_err = 1'b1; mdl_type = ty; mdl_addr = ad;
        end else if (err_clr_i) begin
            mdl_err = 1'b0;
        end
        if (rv) mdl_rdata = rd;
        #1;
    endtask

    function automatic bit rnd_clr();
        return rand_clr_en && ($urandom_range(7) == 0);
    endfunction

    task automatic drive_slaves(input int t, input bit rdy, input bit junk,
                                input logic [31:0] data);
        for (int i = 0; i < NS; i++) begin
            if (i == t) begin
                s_rdata[32*i +: 32] = data;
                s_ready[i] = rdy;
            end else if (junk) begin
                s_rdata[32*i +: 32] = 32'hFFFF_FFFF;
                s_ready[i] = (i == 0) ? 1'b1 : 1'($urandom);
            end else begin
                s_rdata[32*i +: 32] = $urandom;
                s_ready[i] = 1'b0;
            end
        end
    endtask

    task automatic idle(input bit clr);
        m_valid = 1'b0; m_addr = $urandom; err_clr_i = clr | rnd_clr();
        drive_slaves(-1, 1'b0, 1'b1, 32'h0);
        exp_s_valid = '0; exp_m_ready = 1'b0;
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic respond();
        exp_s_valid = '0; exp_m_ready = 1'b1;
        err_clr_i = rnd_clr();
        drive_slaves(-1, 1'b0, 1'b1, 32'h0);
        tick(0, 0, 0, 0, 0);
    endtask

    // One master access; delay = ACTIVE cycles without ready (>= T: timeout),
    // abort_at = ACTIVE cycle index in which m_valid drops (-1: never).
    task automatic run_txn(input logic [31:0] addr, input int delay, input bit junk,
                           input int abort_at, input bit clr0, input logic [31:0] data);
        int t;
        t = model_decode(addr[31:24]);
        m_valid = 1'b1; m_addr = addr; m_wstrb = 4'($urandom); m_wdata = $urandom;
        m_instr = 1'($urandom); err_clr_i = clr0;
        drive_slaves(-1, 1'b0, 1'b0, 32'h0);
        exp_s_valid = '0; exp_m_ready = 1'b0;
        if (t < 0) begin
            tick(1, 0, addr, 1, ERR);
            respond();
            return;
        end
        tick(0, 0, 0, 0, 0);
        for (int j = 0; j < T; j++) begin
            exp_s_valid = '0; exp_s_valid[t] = 1'b1; exp_m_ready = 1'b0;
            err_clr_i = rnd_clr();
            drive_slaves(t, (j == delay) || (j == abort_at), junk, data);
            if (j == abort_at) begin
                m_valid = 1'b0;
                tick(0, 0, 0, 0, 0);
                return;
            end
            if (j == delay) begin
                tick(0, 0, 0, 1, data);
                respond();
                return;
            end
            if (j == T - 1) begin
                tick(1, 1, addr, 1, ERR);
                respond();
                return;
            end
            tick(0, 0, 0, 0, 0);
        end
    endtask

    int start;

    initial begin
        #12;
        chk("rst m_ready", 32'(m_ready), 32'h0);
        chk("rst m_rdata", m_rdata, 32'h0);
        chk("rst s_valid", 32'(s_valid), 32'h0);
        chk("rst err_o", 32'(err_o), 32'h0);
        chk("rst err_type_o", 32'(err_type_o), 32'h0);
        chk("rst err_addr_o", err_addr_o, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk_en = 1'b1;
        idle(0); idle(0);

        // Read to slave 3, ready after 5 ACTIVE cycles
        sv_or = '0; start = cyc;
        run_txn(32'h0400_0010, 5, 0, -1, 0, 32'h1234_5678);
        chk("r33 latency", 32'(ready_cyc - start), 32'd7);
        chk("r33 m_rdata", m_rdata, 32'h1234_5678);
        chk("r33 s_valid seen", 32'(sv_or), 32'h08);

        // Unmapped read
        start = cyc;
        run_txn(32'h0100_0000, 0, 0, -1, 0, 32'h0);
        chk("r34 latency", 32'(ready_cyc - start), 32'd1);
        chk("r34 m_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("r34 err_o", 32'(err_o), 32'h1);
        chk("r34 err_type_o", 32'(err_type_o), 32'h0);
        chk("r34 err_addr_o", err_addr_o, 32'h0100_0000);

        // Timeout on slave 1 (slave 5 shares its region and must lose)
        sv_or = '0; start = cyc;
        run_txn(32'h0200_0040, 100, 0, -1, 0, 32'h5555_AAAA);
        chk("r35 to latency", 32'(ready_cyc - start), 32'd9);
        chk("r35 to m_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("r35 to err_type_o", 32'(err_type_o), 32'h1);
        chk("r35 to err_addr_o", err_addr_o, 32'h0200_0040);
        chk("r35 to s_valid seen", 32'(sv_or), 32'h02);
        idle(1);
        chk("clr err_o", 32'(err_o), 32'h0);
        start = cyc;
        run_txn(32'h0200_0044, 7, 0, -1, 0, 32'hCAFE_0001);
        chk("r35 last latency", 32'(ready_cyc - start), 32'd9);
        chk("r35 last m_rdata", m_rdata, 32'hCAFE_0001);
        chk("r35 last err_o", 32'(err_o), 32'h0);

        // Unselected slave 0 ready with all-ones data during slave 2 transfer
        run_txn(32'h0300_0000, 3, 1, -1, 0, 32'h0BAD_F00D);
        chk("r36 m_rdata", m_rdata, 32'h0BAD_F00D);

        // Clear concurrent with a new unmapped access
        run_txn(32'hFF00_0000, 0, 0, -1, 0, 32'h0);
        run_txn(32'h0600_0008, 0, 0, -1, 1, 32'h0);
        chk("r37 err_o", 32'(err_o), 32'h1);
        chk("r37 err_addr_o", err_addr_o, 32'h0600_0008);

        // Abort in ACTIVE: no response, no error, back to IDLE
        start = cyc; ready_cyc = -1;
        run_txn(32'h0500_0000, 4, 0, 2, 0, 32'h7777_7777);
        idle(0);
        chk("abort no m_ready", 32'(ready_cyc), 32'hFFFF_FFFF);

        // Reset in the middle of ACTIVE
        m_valid = 1'b1; m_addr = 32'h0400_0000; err_clr_i = 1'b0;
        drive_slaves(-1, 1'b0, 1'b0, 32'h0);
        exp_s_valid = '0; exp_m_ready = 1'b0;
        tick(0, 0, 0, 0, 0);
        chk("pre-rst s_valid", 32'(s_valid), 32'h08);
        chk_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("r38 s_valid", 32'(s_valid), 32'h0);
        chk("r38 m_ready", 32'(m_ready), 32'h0);
        chk("r38 m_rdata", m_rdata, 32'h0);
        chk("r38 err_o", 32'(err_o), 32'h0);
        chk("r38 err_addr_o", err_addr_o, 32'h0);
        m_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        mdl_rdata = '0; mdl_err = 1'b0; mdl_type = 1'b0; mdl_addr = '0;
        ready_cyc = -1;
        chk_en = 1'b1;
        for (int k = 0; k < 4; k++) idle(0);
        chk("r38 no m_ready", 32'(ready_cyc), 32'hFFFF_FFFF);

        // Randomized traffic
        rand_clr_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            int d, ab, sel;
            a = $urandom;
            sel = $urandom_range(8);
            if (sel < 6) a[31:24] = region_tbl[sel];
            else if (sel == 6) a[31:24] = 8'h06;
            d = $urandom_range(11);
            ab = ($urandom_range(9) == 0) ? $urandom_range((d < T) ? d : T - 1) : -1;
            run_txn(a, d, 1'($urandom), ab, rnd_clr(), $urandom);
            for (int g = $urandom_range(2); g > 0; g--) idle(0);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
